// File: rtl/piece_queue.sv
// Upcoming-piece queue: filters raw random values into legal piece types,
// suppresses one immediate repeat, and hands pieces to the game FSM on request.
module piece_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_TYPES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rand_data,
    input  logic        spawn_req,
    output logic        spawn_ack,
    output logic [2:0]  spawned_type,
    output logic        piece_valid,
    output logic [2:0]  piece_type,
    output logic [2:0]  next_type,
    output logic [2:0]  queue_count
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] FULL = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    localparam logic [2:0] NO_PIECE = 3'd7;
    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);

    logic [2:0] q      [DEPTH];
    logic [2:0] q_next [DEPTH];
    logic [2:0] count, count_next;
    logic [2:0] last_type;
    logic       reroll_used;
    logic [1:0] state, state_next;

    logic       cand_valid;
    logic [2:0] cand;
    logic       pop, has_room, reroll, enq;

    assign cand_valid = rand_data < 32'(NUM_TYPES);
    assign cand       = rand_data[2:0];

    // A waiting request is served as soon as anything lands; otherwise the
    // ack cycle blocks a second pop so a held request is served every other cycle.
    assign pop      = (state == PEND) ? (count != 3'd0)
                                      : (spawn_req && count != 3'd0 && !spawn_ack);
    assign has_room = (count < DEPTH_C) || pop;
    assign reroll   = cand_valid && has_room && (cand == last_type) && !reroll_used;
    assign enq      = cand_valid && has_room && !reroll;

    always_comb begin
        int wr_idx;
        wr_idx     = int'(count) - (pop ? 1 : 0);
        count_next = 3'(count + {2'b00, enq} - {2'b00, pop});
        for (int i = 0; i < DEPTH; i++) begin
            q_next[i] = q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                q_next[i] = q[i + 1];
            end
        end
        if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == wr_idx) begin
                    q_next[i] = cand;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == PEND) begin
            state_next = pop ? FILL : PEND;
        end else if (spawn_req && count == 3'd0 && !spawn_ack) begin
            state_next = PEND;
        end else begin
            state_next = (count_next == DEPTH_C) ? FULL : FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= 3'd0;
            state        <= FILL;
            spawn_ack    <= 1'b0;
            spawned_type <= 3'd0;
            last_type    <= NO_PIECE;
            reroll_used  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= NO_PIECE;
            end
        end else begin
            count     <= count_next;
            state     <= state_next;
            spawn_ack <= pop;
            if (pop) begin
                spawned_type <= q[0];
            end
            if (enq) begin
                last_type   <= cand;
                reroll_used <= 1'b0;
            end else if (reroll) begin
                reroll_used <= 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_next[i];
            end
        end
    end

    assign piece_valid = (count != 3'd0);
    assign piece_type  = (count != 3'd0) ? q[0] : NO_PIECE;
    assign next_type   = (count > 3'd1)  ? q[1] : NO_PIECE;
    assign queue_count = count;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: fill/drop, reroll, invalid filtering,
// pending requests, pop+push on one edge and asynchronous reset.
module tb_piece_queue;

    localparam logic [31:0] INV = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rand_data;
    logic        spawn_req;
    logic        spawn_ack;
    logic [2:0]  spawned_type;
    logic        piece_valid;
    logic [2:0]  piece_type;
    logic [2:0]  next_type;
    logic [2:0]  queue_count;

    int errorCount = 0;
    int checkCount = 0;

    piece_queue #(.DEPTH(4), .NUM_TYPES(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .rand_data    (rand_data),
        .spawn_req    (spawn_req),
        .spawn_ack    (spawn_ack),
        .spawned_type (spawned_type),
        .piece_valid  (piece_valid),
        .piece_type   (piece_type),
        .next_type    (next_type),
        .queue_count  (queue_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge, so outputs are sampled there too.
    task automatic applyStimulus(input logic [31:0] rd, input logic req);
        rand_data = rd;
        spawn_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic checkQueue(input string tag, input int cnt, input int head, input int nxt);
        checkOutput({tag, ".count"}, 32'(queue_count), 32'(cnt));
        checkOutput({tag, ".head"},  32'(piece_type),  32'(head));
        checkOutput({tag, ".next"},  32'(next_type),   32'(nxt));
        checkOutput({tag, ".valid"}, 32'(piece_valid), (cnt > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic checkAck(input string tag, input logic ack, input int typ);
        checkOutput({tag, ".ack"}, 32'(spawn_ack), 32'(ack));
        checkOutput({tag, ".spawned"}, 32'(spawned_type), 32'(typ));
    endtask

    initial begin
        reset     = 1'b1;
        rand_data = INV;
        spawn_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkQueue("rst", 0, 7, 7);
        checkAck("rst", 1'b0, 0);
        reset = 1'b0;

        // Request on an empty queue waits, then is served once a piece lands.
        applyStimulus(INV, 1'b1);
        checkQueue("pend0", 0, 7, 7);
        checkAck("pend0", 1'b0, 0);
        applyStimulus(32'd3, 1'b0);
        checkQueue("pend1", 1, 3, 7);
        checkAck("pend1", 1'b0, 0);
        applyStimulus(INV, 1'b0);
        checkQueue("pend2", 0, 7, 7);
        checkAck("pend2", 1'b1, 3);
        applyStimulus(INV, 1'b0);
        checkAck("pend3", 1'b0, 3);
        checkQueue("pend3", 0, 7, 7);

        // Fill to full; the fifth value is dropped.
        applyStimulus(32'd2, 1'b0);  checkQueue("fill1", 1, 2, 7);
        applyStimulus(32'd0, 1'b0);  checkQueue("fill2", 2, 2, 0);
        applyStimulus(32'd4, 1'b0);  checkQueue("fill3", 3, 2, 0);
        applyStimulus(32'd1, 1'b0);  checkQueue("fill4", 4, 2, 0);
        applyStimulus(32'd3, 1'b0);  checkQueue("fill5", 4, 2, 0);

        // Pop and push on the same edge while full.
        applyStimulus(32'd3, 1'b1);
        checkAck("popush", 1'b1, 2);
        checkQueue("popush", 4, 0, 4);
        applyStimulus(INV, 1'b0);
        checkAck("popush1", 1'b0, 2);

        // Held request drains every other cycle in FIFO order 0,4,1,3.
        applyStimulus(INV, 1'b1);  checkAck("drain0", 1'b1, 0); checkQueue("drain0", 3, 4, 1);
        applyStimulus(INV, 1'b1);  checkAck("drain1", 1'b0, 0); checkQueue("drain1", 3, 4, 1);
        applyStimulus(INV, 1'b1);  checkAck("drain2", 1'b1, 4); checkQueue("drain2", 2, 1, 3);
        applyStimulus(INV, 1'b1);  checkAck("drain3", 1'b0, 4);
        applyStimulus(INV, 1'b1);  checkAck("drain4", 1'b1, 1); checkQueue("drain4", 1, 3, 7);
        applyStimulus(INV, 1'b1);  checkAck("drain5", 1'b0, 1);
        applyStimulus(INV, 1'b1);  checkAck("drain6", 1'b1, 3); checkQueue("drain6", 0, 7, 7);
        applyStimulus(INV, 1'b0);  checkAck("drain7", 1'b0, 3); checkQueue("drain7", 0, 7, 7);

        // Anti-repeat: 1,1,1,3 gives queue 1,1,3.
        applyStimulus(32'd1, 1'b0);  checkQueue("rr0", 1, 1, 7);
        applyStimulus(32'd1, 1'b0);  checkQueue("rr1", 1, 1, 7);
        applyStimulus(32'd1, 1'b0);  checkQueue("rr2", 2, 1, 1);
        applyStimulus(32'd3, 1'b0);  checkQueue("rr3", 3, 1, 1);
        applyStimulus(INV, 1'b1);
        checkAck("rr4", 1'b1, 1);
        checkQueue("rr4", 2, 1, 3);

        // Back to three entries, then reset in the middle of a cycle.
        applyStimulus(32'd2, 1'b0);  checkQueue("pre_rst", 3, 1, 3);
        rand_data = INV;
        #2;
        reset = 1'b1;
        #1;
        checkQueue("midrst", 0, 7, 7);
        checkAck("midrst", 1'b0, 0);
        #2;
        reset = 1'b0;
        applyStimulus(INV, 1'b0);
        checkAck("postrst", 1'b0, 0);
        checkQueue("postrst", 0, 7, 7);

        // Out-of-range values never enqueue.
        applyStimulus(32'd7, 1'b0);          checkQueue("inv0", 0, 7, 7);
        applyStimulus(32'h0000_0005, 1'b0);  checkQueue("inv1", 0, 7, 7);
        applyStimulus(32'd2, 1'b0);          checkQueue("inv2", 1, 2, 7);
        applyStimulus(32'h8000_0001, 1'b0);  checkQueue("inv3", 1, 2, 7);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
